// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU sequencer: op codes, FSM states and an
// op classification helper.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        OP_XOR  = 2'b00,
        OP_XNOR = 2'b01,
        OP_ADD  = 2'b10,
        OP_SUB  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Arithmetic ops are the ones whose carry chain reaches cout/ovf.
    function automatic logic is_arith(op_t op_v);
        return op_v[1];
    endfunction

endpackage

// File: rtl/serial_alu_seq_alu1bit.sv
// One-bit ALU slice: XOR/XNOR logic path or a full adder, with b inverted for SUB.
module alu1bit
    import serial_alu_pkg::*;
#(
    parameter int unsigned nand_tpd = 1,
    parameter int unsigned or_tpd   = 1,
    parameter int unsigned xnor_tpd = 1
) (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic [1:0] op_i,
    output logic       s_o,
    output logic       cout_o
);

    // Gate delays only characterise timing; the synthesizable slice is zero-delay.
    if (nand_tpd + or_tpd + xnor_tpd == 0) begin : g_zero_tpd
    end

    op_t  op_v;
    logic b_eff;
    logic p;

    assign op_v  = op_t'(op_i);
    assign b_eff = b_i ^ (op_v == OP_SUB);
    assign p     = a_i ^ b_eff;

    always_comb begin
        s_o    = 1'b0;
        cout_o = (a_i & b_eff) | (cin_i & p);
        unique case (op_v)
            OP_XOR:  s_o = a_i ^ b_i;
            OP_XNOR: s_o = ~(a_i ^ b_i);
            OP_ADD,
            OP_SUB:  s_o = p ^ cin_i;
            default: s_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial WIDTH-bit ALU sequencer: feeds one alu1bit slice LSB-first, one bit per
// clock, and reports result, carry-out and signed overflow with a done pulse.
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned nand_tpd = 1,
    parameter int unsigned or_tpd   = 1,
    parameter int unsigned xnor_tpd = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    op_t              op_q, op_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic alu_s;
    logic alu_cout;

    alu1bit #(
        .nand_tpd (nand_tpd),
        .or_tpd   (or_tpd),
        .xnor_tpd (xnor_tpd)
    ) u_alu1bit (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .op_i   (op_q),
        .s_o    (alu_s),
        .cout_o (alu_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE,
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = op_t'(op);
                    cnt_d   = '0;
                    // SUB is a + ~b + 1: the +1 enters as the initial carry.
                    carry_d = (op_t'(op) == OP_SUB);
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                result_d = {alu_s, result_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = alu_cout;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = DONE;
                    // carry_q here is the carry into the MSB.
                    cout_d  = is_arith(op_q) ? alu_cout : 1'b0;
                    ovf_d   = is_arith(op_q) ? (carry_q ^ alu_cout) : 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            op_q     <= OP_XOR;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq (WIDTH=8): directed cases plus randomized ops
// against an arithmetic reference model.
module tb_serial_alu_seq;

    localparam int W = 8;
    localparam int Latency = W + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int checks;
    int errors;
    int edges;

    serial_alu_seq #(
        .WIDTH    (W),
        .nand_tpd (1),
        .or_tpd   (1),
        .xnor_tpd (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain two's-complement arithmetic on whole words.
    task automatic model(input logic [1:0] m_op, input logic [W-1:0] ma, input logic [W-1:0] mb,
                         output logic [W-1:0] r, output logic c, output logic v);
        logic [W:0] sum;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (m_op)
            2'b00: r = ma ^ mb;
            2'b01: r = ~(ma ^ mb);
            2'b10: begin
                sum = {1'b0, ma} + {1'b0, mb};
                r = sum[W-1:0];
                c = sum[W];
                v = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
            end
            default: begin
                sum = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
                r = sum[W-1:0];
                c = sum[W];
                v = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
            end
        endcase
    endtask

    // All tasks begin and end at a negedge.
    task automatic issue(input logic [1:0] i_op, input logic [W-1:0] ia, input logic [W-1:0] ib);
        start = 1'b1;
        op    = i_op;
        a     = ia;
        b     = ib;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        while (!done && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, "_latency"}, edges, Latency);
    endtask

    task automatic check_result(input string tag, input logic [1:0] c_op,
                                input logic [W-1:0] ca, input logic [W-1:0] cb);
        logic [W-1:0] r;
        logic c;
        logic v;
        model(c_op, ca, cb, r, c, v);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_result"}, result, r);
        check({tag, "_cout"}, cout, c);
        check({tag, "_ovf"}, ovf, v);
    endtask

    task automatic run_op(input string tag, input logic [1:0] r_op,
                          input logic [W-1:0] ra, input logic [W-1:0] rb);
        issue(r_op, ra, rb);
        check({tag, "_busy_run"}, busy, 1);
        wait_done(tag);
        check_result(tag, r_op, ra, rb);
    endtask

    task automatic idle_after(input string tag, input logic [W-1:0] held);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_held"}, result, held);
    endtask

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        checks = 0;
        errors = 0;
        edges  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);

        run_op("add5a3c", 2'b10, 8'h5A, 8'h3C);
        check("add5a3c_exp", {result, cout, ovf}, {8'h96, 1'b0, 1'b1});
        idle_after("add5a3c", 8'h96);

        run_op("sub10_01", 2'b11, 8'h10, 8'h01);
        check("sub10_01_exp", {result, cout, ovf}, {8'h0F, 1'b1, 1'b0});
        run_op("sub00_01", 2'b11, 8'h00, 8'h01);
        check("sub00_01_exp", {result, cout, ovf}, {8'hFF, 1'b0, 1'b0});
        run_op("xor", 2'b00, 8'hF0, 8'hAA);
        check("xor_exp", {result, cout, ovf}, {8'h5A, 1'b0, 1'b0});
        run_op("xnor", 2'b01, 8'hF0, 8'hAA);
        check("xnor_exp", {result, cout, ovf}, {8'hA5, 1'b0, 1'b0});

        // Wrap-around then back-to-back start issued in the DONE cycle.
        run_op("addff01", 2'b10, 8'hFF, 8'h01);
        check("addff01_exp", {result, cout, ovf}, {8'h00, 1'b1, 1'b0});
        issue(2'b10, 8'h01, 8'h01);
        check("b2b_busy", busy, 1);
        wait_done("b2b");
        check_result("b2b", 2'b10, 8'h01, 8'h01);
        check("b2b_exp", result, 8'h02);
        idle_after("b2b", 8'h02);

        // Start pulsed during RUN must be ignored.
        issue(2'b10, 8'h11, 8'h22);
        repeat (2) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b1;
        op    = 2'b11;
        a     = 8'hFF;
        @(posedge clk);
        edges++;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", busy, 1);
        check("ign_done", done, 0);
        wait_done("ign");
        check_result("ign", 2'b10, 8'h11, 8'h22);
        check("ign_exp", result, 8'h33);
        idle_after("ign", 8'h33);

        // Reset after 3 RUN edges aborts the operation.
        issue(2'b10, 8'h7F, 8'h01);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_cout", cout, 0);
        check("abort_ovf", ovf, 0);
        @(posedge clk);
        @(negedge clk);
        check("abort_stays_idle", {busy, done}, 2'b00);
        run_op("post_abort", 2'b10, 8'h7F, 8'h01);
        idle_after("post_abort", 8'h80);

        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            run_op($sformatf("rand%0d", i), r_op, ra, rb);
            if ($urandom_range(0, 1) == 0) begin
                idle_after($sformatf("rand%0d", i), result);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
